instruction_decoder: RTL and testbench

Decodes the 8-bit instruction word returned by program memory for the current program counter and drives the program sequencer's flow-control inputs (jmp, jmp_nz, jmp_addr, dont_jmp, NOPCF) plus datapath register-load enables, source selects and ALU function. It sits between program memory and the sequencer and datapath. It owns two pieces of state: the zero flag behind dont_jmp and the loop-arm state machine behind NOPCF.

---
 rtl/instruction_decoder.sv | 122 ++++++++++++
 tb/tb_instruction_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// ---------------------------------------------------------------------------
// instruction_decoder
//
// Decodes the 8-bit program-memory word for the current pc into sequencer
// flow-control strobes and datapath load enables / selects / ALU function.
// Decode is purely combinational (zero latency); the block owns two state
// bits: the zero flag behind dont_jmp and the loop-arm FSM behind NOPCF.
//
// Configuration macro: NOPCF_ONESHOT_EN
//   defined   : only the first 8'hBF after reset raises NOPCF; later ones
//               are no-ops while the FSM sits in ARMED.
//   undefined : every 8'hBF raises NOPCF (re-arming the loop window).
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset; forces every output to 0
//   pm_data    in   [7:0] instruction at current pc
//   alu_zero   in   ALU result-is-zero for the executing ALU instruction
//   jmp        out  unconditional jump strobe
//   jmp_nz     out  conditional jump strobe
//   jmp_addr   out  [3:0] jump target high nibble
//   dont_jmp   out  registered zero flag
//   NOPCF      out  loop-arm strobe
//   reg_en     out  [7:0] one-hot load enable (x0,x1,y0,y1,r,m,i,o_reg)
//   src_sel    out  [2:0] move source select
//   imm_sel    out  1 = immediate load
//   imm_data   out  [3:0] immediate value
//   alu_func   out  [3:0] ALU function code
//   loop_armed out  loop FSM state (1 = ARMED)
// ---------------------------------------------------------------------------
module instruction_decoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pm_data,
    input  logic       alu_zero,
    output logic       jmp,
    output logic       jmp_nz,
    output logic [3:0] jmp_addr,
    output logic       dont_jmp,
    output logic       NOPCF,
    output logic [7:0] reg_en,
    output logic [2:0] src_sel,
    output logic       imm_sel,
    output logic [3:0] imm_data,
    output logic [3:0] alu_func,
    output logic       loop_armed
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } loop_state_e;

    loop_state_e state_q, state_d;
    logic        z_q, z_d;
    logic        is_alu;
    logic        is_loop;

    // Instruction classes are picked off the leading-ones prefix. 8'hBF
    // sits inside the move space but is carved out as the loop-arm opcode.
    // Everything is gated by reset_n so outputs drop without a clock.
    always_comb begin
        jmp      = 1'b0;
        jmp_nz   = 1'b0;
        jmp_addr = 4'h0;
        reg_en   = 8'h00;
        src_sel  = 3'b000;
        imm_sel  = 1'b0;
        imm_data = 4'h0;
        alu_func = 4'h0;
        is_alu   = 1'b0;
        is_loop  = 1'b0;
        if (reset_n) begin
            if (!pm_data[7]) begin
                reg_en[pm_data[6:4]] = 1'b1;
                imm_sel              = 1'b1;
                imm_data             = pm_data[3:0];
            end else if (pm_data == 8'hBF) begin
                is_loop = 1'b1;
            end else if (!pm_data[6]) begin
                reg_en[pm_data[5:3]] = 1'b1;
                src_sel              = pm_data[2:0];
            end else if (!pm_data[5]) begin
                is_alu   = 1'b1;
                alu_func = pm_data[3:0];
                reg_en[pm_data[4] ? 3'd3 : 3'd0] = 1'b1;
            end else if (!pm_data[4]) begin
                jmp      = 1'b1;
                jmp_addr = pm_data[3:0];
            end else begin
                jmp_nz   = 1'b1;
                jmp_addr = pm_data[3:0];
            end
        end
    end

`ifdef NOPCF_ONESHOT_EN
    // Once armed, further loop-arm opcodes are silent no-ops.
    assign NOPCF = is_loop && (state_q == IDLE);
`else
    assign NOPCF = is_loop;
`endif

    // ARMED is absorbing; only reset leaves it.
    assign state_d = is_loop ? ARMED : state_q;
    // Flag samples alu_zero only on edges that retire an ALU op.
    assign z_d     = is_alu ? alu_zero : z_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign dont_jmp   = z_q;
    assign loop_armed = (state_q == ARMED);

endmodule

// File: tb/tb_instruction_decoder.sv
module tb_instruction_decoder;

    logic       clk;
    logic       reset_n;
    logic [7:0] pm_data;
    logic       alu_zero;
    logic       jmp, jmp_nz, dont_jmp, NOPCF, imm_sel, loop_armed;
    logic [3:0] jmp_addr, imm_data, alu_func;
    logic [7:0] reg_en;
    logic [2:0] src_sel;

    instruction_decoder dut (
        .clk(clk), .reset_n(reset_n), .pm_data(pm_data), .alu_zero(alu_zero),
        .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr), .dont_jmp(dont_jmp),
        .NOPCF(NOPCF), .reg_en(reg_en), .src_sel(src_sel), .imm_sel(imm_sel),
        .imm_data(imm_data), .alu_func(alu_func), .loop_armed(loop_armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

`ifdef NOPCF_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    // Reference model state: zero flag and "has a loop been armed".
    bit m_z;
    bit m_armed;

    wire [28:0] dut_vec = {jmp, jmp_nz, jmp_addr, dont_jmp, NOPCF, reg_en,
                           src_sel, imm_sel, imm_data, alu_func, loop_armed};

    // Expected outputs computed from the opcode value with plain arithmetic.
    function automatic logic [28:0] exp_vec(input int pm, input bit rst_n_v);
        bit e_jmp = 0, e_jnz = 0, e_nop = 0, e_imm = 0;
        int e_addr = 0, e_regen = 0, e_src = 0, e_immd = 0, e_alu = 0;
        if (!rst_n_v) return '0;
        if (pm < 128) begin
            e_regen = 1 << ((pm / 16) % 8);
            e_imm   = 1;
            e_immd  = pm % 16;
        end else if (pm == 191) begin
            e_nop = ONESHOT ? !m_armed : 1'b1;
        end else if (pm < 192) begin
            e_regen = 1 << ((pm / 8) % 8);
            e_src   = pm % 8;
        end else if (pm < 224) begin
            e_alu   = pm % 16;
            e_regen = ((pm / 16) % 2) ? 8 : 1;
        end else if (pm < 240) begin
            e_jmp  = 1;
            e_addr = pm % 16;
        end else begin
            e_jnz  = 1;
            e_addr = pm % 16;
        end
        return {e_jmp, e_jnz, 4'(e_addr), m_z, e_nop, 8'(e_regen), 3'(e_src),
                e_imm, 4'(e_immd), 4'(e_alu), m_armed};
    endfunction

    // Advance the model across one rising edge using the inputs held there.
    function automatic void model_edge();
        if (!reset_n) begin
            m_z = 0; m_armed = 0;
        end else begin
            if (pm_data >= 8'hC0 && pm_data < 8'hE0) m_z = alu_zero;
            if (pm_data == 8'hBF) m_armed = 1;
        end
    endfunction

    // Apply one instruction shortly after an edge; checks happen in callers.
    task automatic drive(input logic [7:0] pm, input logic az);
        pm_data  = pm;
        alu_zero = az;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; m_z = 0; m_armed = 0;
        drive(8'hE5, 1'b0);
        tick(); tick();
        drive(8'hE5, 1'b0);
        n_total++; if (jmp !== 1'b0) $display("FAIL reset_jmp got %b exp 0", jmp); else n_pass++;
        n_total++; if (jmp_addr !== 4'h0) $display("FAIL reset_jmp_addr got %h exp 0", jmp_addr); else n_pass++;
        n_total++; if (dont_jmp !== 1'b0) $display("FAIL reset_dont_jmp got %b exp 0", dont_jmp); else n_pass++;
        n_total++; if (loop_armed !== 1'b0) $display("FAIL reset_loop_armed got %b exp 0", loop_armed); else n_pass++;
        n_total++; if (dut_vec !== '0) $display("FAIL reset_all got %h exp 0", dut_vec); else n_pass++;
        reset_n = 1;
        drive(8'hE5, 1'b0);
        n_total++; if (jmp !== 1'b1) $display("FAIL release_jmp got %b exp 1", jmp); else n_pass++;
        n_total++; if (jmp_addr !== 4'h5) $display("FAIL release_jmp_addr got %h exp 5", jmp_addr); else n_pass++;
        tick();
    endtask

    task automatic test_load_move();
        drive(8'h3A, 1'b0);
        n_total++; if (reg_en !== 8'h08) $display("FAIL load_reg_en got %h exp 08", reg_en); else n_pass++;
        n_total++; if (imm_sel !== 1'b1) $display("FAIL load_imm_sel got %b exp 1", imm_sel); else n_pass++;
        n_total++; if (imm_data !== 4'hA) $display("FAIL load_imm_data got %h exp a", imm_data); else n_pass++;
        tick();
        drive(8'h9D, 1'b0);
        n_total++; if (reg_en !== 8'h08) $display("FAIL move_reg_en got %h exp 08", reg_en); else n_pass++;
        n_total++; if (src_sel !== 3'b101) $display("FAIL move_src_sel got %b exp 101", src_sel); else n_pass++;
        n_total++; if (imm_sel !== 1'b0) $display("FAIL move_imm_sel got %b exp 0", imm_sel); else n_pass++;
        tick();
    endtask

    task automatic test_flag_jnz();
        drive(8'hC2, 1'b1);
        n_total++; if (reg_en !== 8'h01 || alu_func !== 4'h2) $display("FAIL alu_decode got %h/%h exp 01/2", reg_en, alu_func); else n_pass++;
        tick();
        drive(8'hF7, 1'b0);
        n_total++; if (jmp_nz !== 1'b1 || jmp_addr !== 4'h7) $display("FAIL jnz_decode got %b/%h exp 1/7", jmp_nz, jmp_addr); else n_pass++;
        n_total++; if (dont_jmp !== 1'b1) $display("FAIL flag_set got %b exp 1", dont_jmp); else n_pass++;
        tick();
        // Non-ALU op in between must not disturb the flag, even with alu_zero low.
        drive(8'h05, 1'b0);
        tick();
        drive(8'hF7, 1'b0);
        n_total++; if (dont_jmp !== 1'b1) $display("FAIL flag_hold got %b exp 1", dont_jmp); else n_pass++;
        tick();
        drive(8'hD2, 1'b0);
        n_total++; if (reg_en !== 8'h08) $display("FAIL alu_r1_reg_en got %h exp 08", reg_en); else n_pass++;
        tick();
        drive(8'hF7, 1'b1);
        n_total++; if (dont_jmp !== 1'b0) $display("FAIL flag_clear got %b exp 0", dont_jmp); else n_pass++;
        tick();
    endtask

    task automatic test_loop_arm();
        drive(8'hBF, 1'b0);
        n_total++; if (NOPCF !== 1'b1) $display("FAIL loop_first_nopcf got %b exp 1", NOPCF); else n_pass++;
        n_total++; if (reg_en !== 8'h00) $display("FAIL loop_no_reg_en got %h exp 00", reg_en); else n_pass++;
        n_total++; if (loop_armed !== 1'b0) $display("FAIL loop_pre_state got %b exp 0", loop_armed); else n_pass++;
        tick();
        drive(8'h12, 1'b0);
        n_total++; if (loop_armed !== 1'b1) $display("FAIL loop_armed got %b exp 1", loop_armed); else n_pass++;
        tick();
        drive(8'h88, 1'b0); tick();
        drive(8'hE3, 1'b0); tick();
        drive(8'hBF, 1'b0);
        n_total++; if (NOPCF !== !ONESHOT) $display("FAIL loop_second_nopcf got %b exp %b", NOPCF, !ONESHOT); else n_pass++;
        tick();
        n_total++; if (loop_armed !== 1'b1) $display("FAIL loop_stays_armed got %b exp 1", loop_armed); else n_pass++;
    endtask

    task automatic test_mid_reset();
        drive(8'hC0, 1'b1); tick();
        drive(8'h00, 1'b0);
        n_total++; if (dont_jmp !== 1'b1 || loop_armed !== 1'b1) $display("FAIL pre_reset got %b/%b exp 1/1", dont_jmp, loop_armed); else n_pass++;
        reset_n = 0; m_z = 0; m_armed = 0;
        #1;
        n_total++; if (loop_armed !== 1'b0) $display("FAIL midrst_loop_armed got %b exp 0", loop_armed); else n_pass++;
        n_total++; if (dont_jmp !== 1'b0) $display("FAIL midrst_dont_jmp got %b exp 0", dont_jmp); else n_pass++;
        #2;
        reset_n = 1;
        tick();
        drive(8'hBF, 1'b0);
        n_total++; if (NOPCF !== 1'b1) $display("FAIL midrst_nopcf got %b exp 1", NOPCF); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] pm;
        logic [28:0] exp;
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            if (!reset_n) begin m_z = 0; m_armed = 0; end
            pm = ($urandom_range(0, 9) == 0) ? 8'hBF : 8'($urandom);
            drive(pm, 1'($urandom));
            exp = exp_vec(int'(pm), reset_n);
            n_total++;
            if (dut_vec !== exp)
                $display("FAIL random c%0d pm=%h rst_n=%b got %h exp %h", c, pm, reset_n, dut_vec, exp);
            else n_pass++;
            tick();
        end
        reset_n = 1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 0;
        pm_data  = 8'h00;
        alu_zero = 1'b0;
        #1;
        test_reset();
        test_load_move();
        test_flag_jnz();
        test_loop_arm();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
